sdf_query_cube: RTL and testbench
=================================

SDF_QUERY_CUBE -- requirements
Module: sdf_query_cube

Interface
REQ-001 The module SHALL have parameter FP_WIDTH, default 32, signed fixed-point word width.
REQ-002 The module SHALL have parameter FRAC_BITS, default 16, fractional bits per word (Q16.16 by default).
REQ-003 The module SHALL have parameter HALF_SIZE, default 1<<FRAC_BITS (1.0), cube half-extent, positive, cube centred at origin.
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk_in  input  1  clock, all state on rising edge.
REQ-006 rst_in  input  1  asynchronous, active-low reset.
REQ-007 point_in  input  3*FP_WIDTH  query point, packed {x,y,z}, x in MSBs, each signed fixed-point.
REQ-008 valid_in  input  1  point_in valid this cycle.
REQ-009 ready_out  output  1  module idle and able to accept a point.
REQ-010 valid_out  output  1  one-cycle pulse, sdf_out holds a new result.
REQ-011 sdf_out  output  FP_WIDTH  signed signed-distance result, same format as inputs.

Function
REQ-012 Distance SHALL be: q = |p| - HALF_SIZE per axis; sdf = length(max(q,0)) + min(max(qx,qy,qz),0).
REQ-013 States SHALL be IDLE, QCALC, SUMSQ, ROOT, OUT; ready_out SHALL be 1 only in IDLE.
REQ-014 IDLE: when valid_in=1, register point_in and go to QCALC; otherwise stay.
REQ-015 QCALC: compute |p| (most-negative input saturates to max positive), subtract HALF_SIZE, and register q and clamped max(q,0); go to SUMSQ.
REQ-016 SUMSQ: sum of squares of clamped components in 2*FP_WIDTH unsigned bits (2*FRAC_BITS fraction), saturating to all-ones on overflow; go to ROOT.
REQ-017 ROOT: restoring bit-serial integer square root, one result bit per cycle, exactly FP_WIDTH cycles, truncating; result is directly in FRAC_BITS format.
REQ-018 OUT: sdf_out SHALL be loaded with root (saturated to max positive) plus interior term, and valid_out SHALL be 1 for this single cycle; next state IDLE.
REQ-019 Latency SHALL be FP_WIDTH+3 rising edges from the accepting edge to the edge that sets valid_out (35 by default); throughput one point per FP_WIDTH+4 cycles.
REQ-020 valid_in while ready_out=0 SHALL be ignored; no queuing.
REQ-021 sdf_out SHALL hold its value between valid_out pulses.
REQ-022 Exterior and interior terms are never both nonzero; the final add SHALL not overflow.

Reset
REQ-023 rst_in low SHALL immediately force state IDLE, ready_out=1, valid_out=0, sdf_out=0, and clear all datapath registers.
REQ-024 Reset during any busy state SHALL abort the computation with no valid_out pulse; the first edge with rst_in high SHALL behave as IDLE.

Configuration
REQ-025 Macro SDF_CUBE_INTERIOR_EN defined: interior term included per REQ-012, so points inside the cube return negative distances.
REQ-026 SDF_CUBE_INTERIOR_EN undefined: interior term SHALL be forced to 0, so points inside or on the cube return 0; latency and handshake unchanged.

Verification
REQ-027 Point (0,0,0), macro defined -> after 35 edges valid_out=1, sdf_out=0xFFFF0000 (-1.0); macro undefined -> 0x00000000.
REQ-028 Point (3.0,0,0) -> sdf_out=0x00020000; point (-4.0,0,-5.0) -> 0x00050000 (5.0).
REQ-029 Point (2.0,2.0,1.0) -> sdf_out=0x00016A09 (sqrt2, truncated).
REQ-030 Pulse valid_in with a second point during ROOT -> second point ignored, one valid_out, ready_out returns to 1 the cycle after the pulse.
REQ-031 Drive rst_in low mid-ROOT -> ready_out=1, valid_out=0, sdf_out=0 asynchronously, no later pulse; a new point after release yields the correct result.

Source files
------------

// File: rtl/sdf_query_cube.sv
// Signed distance from a Q-format point to an origin-centred cube, computed serially (one root bit per cycle).
// Optional macro SDF_CUBE_INTERIOR_EN: include the negative interior term for points inside the cube.
module sdf_query_cube #(
  parameter int FP_WIDTH  = 32,
  parameter int FRAC_BITS = 16,
  parameter int HALF_SIZE = 1 << FRAC_BITS
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [3*FP_WIDTH-1:0] point_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  valid_out,
  output logic [FP_WIDTH-1:0]   sdf_out
);

  localparam int W  = FP_WIDTH;
  localparam int CW = $clog2(FP_WIDTH);
  localparam logic signed [W-1:0] HALF_V    = W'(HALF_SIZE);
  localparam logic signed [W-1:0] MAX_POS   = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_NEG   = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0]       ROOT_LAST = CW'(W-1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    QCALC = 3'd1,
    SUMSQ = 3'd2,
    ROOT  = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t              state_r, state_next_s;
  logic [CW-1:0]       cnt_r;
  logic signed [W-1:0] p_r [3];
  logic [W-1:0]        qc_r [3];
  logic [2*W-1:0]      rad_r;
  logic [W-1:0]        rem_r;
  logic [W-1:0]        root_r;
  logic                ready_r;
  logic                valid_r;
  logic [W-1:0]        sdf_r;

  logic signed [W-1:0] q_s [3];
  logic [2*W-1:0]      ext_s [3];
  logic [2*W+1:0]      sum_s;
  logic [2*W-1:0]      rad_sat_s;
  logic [W+1:0]        rem_shift_s;
  logic [W+1:0]        trial_s;
  logic [W-1:0]        diff_s;
  logic                take_s;
  logic signed [W-1:0] root_sat_s;
  logic signed [W-1:0] interior_s;
`ifdef SDF_CUBE_INTERIOR_EN
  logic signed [W-1:0] qmax_s;
  logic signed [W-1:0] qmax_r;
`endif

  // Absolute value; the most negative code has no positive twin, so it saturates.
  function automatic logic signed [W-1:0] abs_sat(input logic signed [W-1:0] v);
    if (v == MIN_NEG) begin
      abs_sat = MAX_POS;
    end else if (v[W-1]) begin
      abs_sat = -v;
    end else begin
      abs_sat = v;
    end
  endfunction

  // Clamp a signed component to zero from below.
  function automatic logic [W-1:0] clamp_pos(input logic signed [W-1:0] v);
    if (v[W-1]) begin
      clamp_pos = {W{1'b0}};
    end else begin
      clamp_pos = v;
    end
  endfunction

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (valid_in) begin
          state_next_s = QCALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      QCALC: state_next_s = SUMSQ;
      SUMSQ: state_next_s = ROOT;
      ROOT: begin
        if (cnt_r == ROOT_LAST) begin
          state_next_s = OUT;
        end else begin
          state_next_s = ROOT;
        end
      end
      OUT:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Per-axis distance to the face planes and sum of squares of the exterior parts.
  always_comb begin
    sum_s = {(2*W+2){1'b0}};
    for (int i = 0; i < 3; i++) begin
      q_s[i]   = abs_sat(p_r[i]) - HALF_V;
      ext_s[i] = {{W{1'b0}}, qc_r[i]};
      sum_s    = sum_s + {2'b00, ext_s[i] * ext_s[i]};
    end
    if (sum_s[2*W+1:2*W] != 2'b00) begin
      rad_sat_s = {(2*W){1'b1}};
    end else begin
      rad_sat_s = sum_s[2*W-1:0];
    end
  end

  // One restoring square-root step: bring down two radicand bits, try appending a 1.
  always_comb begin
    rem_shift_s = {rem_r, rad_r[2*W-1:2*W-2]};
    trial_s     = {root_r, 2'b01};
    take_s      = (rem_shift_s >= trial_s);
    diff_s      = rem_shift_s[W-1:0] - trial_s[W-1:0];
  end

  // Saturated root plus interior term (interior is nonzero only when the exterior is zero).
  always_comb begin
    if (root_r[W-1]) begin
      root_sat_s = MAX_POS;
    end else begin
      root_sat_s = $signed(root_r);
    end
`ifdef SDF_CUBE_INTERIOR_EN
    qmax_s = q_s[0];
    if (q_s[1] > qmax_s) begin
      qmax_s = q_s[1];
    end else begin
      qmax_s = qmax_s;
    end
    if (q_s[2] > qmax_s) begin
      qmax_s = q_s[2];
    end else begin
      qmax_s = qmax_s;
    end
    if (qmax_r[W-1]) begin
      interior_s = qmax_r;
    end else begin
      interior_s = {W{1'b0}};
    end
`else
    interior_s = {W{1'b0}};
`endif
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 3; i++) begin
        p_r[i]  <= {W{1'b0}};
        qc_r[i] <= {W{1'b0}};
      end
      rad_r   <= {(2*W){1'b0}};
      rem_r   <= {W{1'b0}};
      root_r  <= {W{1'b0}};
      cnt_r   <= {CW{1'b0}};
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      sdf_r   <= {W{1'b0}};
`ifdef SDF_CUBE_INTERIOR_EN
      qmax_r  <= {W{1'b0}};
`endif
    end else begin
      ready_r <= (state_next_s == IDLE);
      valid_r <= (state_r == OUT);
      case (state_r)
        IDLE: begin
          if (valid_in) begin
            p_r[0] <= point_in[3*W-1:2*W];
            p_r[1] <= point_in[2*W-1:W];
            p_r[2] <= point_in[W-1:0];
          end
        end
        QCALC: begin
          for (int i = 0; i < 3; i++) begin
            qc_r[i] <= clamp_pos(q_s[i]);
          end
`ifdef SDF_CUBE_INTERIOR_EN
          qmax_r <= qmax_s;
`endif
        end
        SUMSQ: begin
          rad_r  <= rad_sat_s;
          rem_r  <= {W{1'b0}};
          root_r <= {W{1'b0}};
          cnt_r  <= {CW{1'b0}};
        end
        ROOT: begin
          rad_r  <= {rad_r[2*W-3:0], 2'b00};
          rem_r  <= take_s ? diff_s : rem_shift_s[W-1:0];
          root_r <= {root_r[W-2:0], take_s};
          cnt_r  <= cnt_r + CW'(1);
        end
        OUT: begin
          sdf_r <= root_sat_s + interior_s;
        end
        default: ;
      endcase
    end
  end

  assign ready_out = ready_r;
  assign valid_out = valid_r;
  assign sdf_out   = sdf_r;

endmodule

// File: tb/tb_sdf_query_cube.sv
// Scoreboard bench for sdf_query_cube: directed vectors, random points, busy-ignore and mid-root reset.
module tb_sdf_query_cube;

  logic        clk_in;
  logic        rst_in;
  logic [95:0] point_in;
  logic        valid_in;
  logic        ready_out;
  logic        valid_out;
  logic [31:0] sdf_out;

  int errors;
  int checks;
  logic [31:0] exp_q [$];

  sdf_query_cube dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .point_in (point_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .valid_out(valid_out),
    .sdf_out  (sdf_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  function automatic logic [95:0] pt(input int x, input int y, input int z);
    logic [31:0] xv, yv, zv;
    xv = x; yv = y; zv = z;
    return {xv, yv, zv};
  endfunction

  // Independent reference: greedy bit-by-bit square root on a wide sum of squares.
  function automatic logic [31:0] model_sdf(input logic [95:0] p);
    logic signed [31:0] c, a, q, qmax;
    logic [65:0] sum, t;
    logic [31:0] r, res;
    sum = 66'd0; qmax = 32'sd0; r = 32'd0;
    for (int i = 0; i < 3; i++) begin
      c = p[95-32*i -: 32];
      if (c == 32'sh80000000) a = 32'sh7FFFFFFF;
      else if (c < 0) a = -c;
      else a = c;
      q = a - 32'sh00010000;
      if (i == 0 || q > qmax) qmax = q;
      if (q > 0) begin
        t = {34'd0, q};
        sum = sum + t * t;
      end
    end
    if (sum[65:64] != 2'b00) sum = {2'b00, {64{1'b1}}};
    for (int b = 31; b >= 0; b--) begin
      t = {34'd0, r | (32'd1 << b)};
      if (t * t <= sum) r = r | (32'd1 << b);
    end
    res = r[31] ? 32'h7FFFFFFF : r;
`ifdef SDF_CUBE_INTERIOR_EN
    if (qmax < 0) res = res + qmax;
`endif
    return res;
  endfunction

  // Enter and leave at a falling edge; ok=0 if the DUT never became ready.
  task automatic send_point(input logic [95:0] p, output bit ok);
    int n;
    n = 0;
    while (!ready_out && n < 60) begin
      @(negedge clk_in);
      n++;
    end
    ok = ready_out;
    point_in = p;
    valid_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  // Count rising edges until valid_out is seen, bounded.
  task automatic collect(output logic [31:0] v, output int lat, output bit seen);
    lat = 0;
    while (!valid_out && lat < 100) begin
      @(negedge clk_in);
      lat++;
    end
    seen = valid_out;
    v = sdf_out;
  endtask

  task automatic test_reset;
    rst_in = 1'b0; valid_in = 1'b0; point_in = 96'd0;
    @(negedge clk_in);
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid_out); end
    checks++; if (sdf_out !== 32'h0) begin errors++; $display("FAIL reset_sdf got=%h want=00000000", sdf_out); end
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      errors++; $display("FAIL idle_after_reset valid=%b ready=%b want 0/1", valid_out, ready_out);
    end
  endtask

  task automatic test_vectors;
    logic [95:0] pts [8];
    logic [31:0] exps [8];
    logic [31:0] v, want;
    int lat;
    bit ok, seen;
    pts[0] = pt(0, 0, 0);
`ifdef SDF_CUBE_INTERIOR_EN
    exps[0] = 32'hFFFF0000;
`else
    exps[0] = 32'h00000000;
`endif
    pts[1] = pt(3 << 16, 0, 0);              exps[1] = 32'h00020000;
    pts[2] = pt(-(4 << 16), 0, -(5 << 16));  exps[2] = 32'h00050000;
    pts[3] = pt(2 << 16, 2 << 16, 1 << 16);  exps[3] = 32'h00016A09;
    pts[4] = pt(1 << 16, 0, 0);              exps[4] = 32'h00000000;
    pts[5] = pt(32'sh80000000, 0, 0);        exps[5] = 32'h7FFEFFFF;
    pts[6] = pt(32'sh80000000, 32'sh80000000, 32'sh80000000); exps[6] = 32'h7FFFFFFF;
    pts[7] = pt(32'sh00008000, 0, 0);
`ifdef SDF_CUBE_INTERIOR_EN
    exps[7] = 32'hFFFF8000;
`else
    exps[7] = 32'h00000000;
`endif
    for (int i = 0; i < 8; i++) begin
      send_point(pts[i], ok);
      exp_q.push_back(exps[i]);
      checks++; if (!ok) begin errors++; $display("FAIL vec%0d_ready got=0 want=1", i); end
      collect(v, lat, seen);
      checks++; if (!seen) begin errors++; $display("FAIL vec%0d_timeout got=no_valid want=valid", i); end
      checks++; if (lat !== 35) begin errors++; $display("FAIL vec%0d_latency got=%0d want=35", i, lat); end
      want = exp_q.pop_front();
      checks++; if (v !== want) begin errors++; $display("FAIL vec%0d_sdf got=%h want=%h", i, v, want); end
      @(negedge clk_in);
      checks++; if (valid_out !== 1'b0 || sdf_out !== want) begin
        errors++; $display("FAIL vec%0d_hold valid=%b sdf=%h want 0/%h", i, valid_out, sdf_out, want);
      end
    end
  endtask

  task automatic test_random;
    logic [95:0] p;
    logic [31:0] v, want;
    int lat, x, y, z;
    bit ok, seen;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        x = int'($urandom_range(0, 16 << 16)) - (8 << 16);
        y = int'($urandom_range(0, 4 << 16)) - (2 << 16);
        z = int'($urandom_range(0, 16 << 16)) - (8 << 16);
      end else begin
        x = int'($urandom); y = int'($urandom); z = int'($urandom);
      end
      p = pt(x, y, z);
      send_point(p, ok);
      exp_q.push_back(model_sdf(p));
      collect(v, lat, seen);
      want = exp_q.pop_front();
      checks++; if (!ok || !seen || v !== want) begin
        errors++; $display("FAIL rand%0d_sdf got=%h want=%h seen=%b pt=%h", i, v, want, seen, p);
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_ignore_busy;
    logic [31:0] v, want;
    int lat, pulses;
    bit ok, seen;
    send_point(pt(3 << 16, 0, 0), ok);
    exp_q.push_back(32'h00020000);
    repeat (10) @(negedge clk_in);
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL busy_ready got=%b want=0", ready_out); end
    point_in = pt(-(4 << 16), 0, -(5 << 16));
    valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
    collect(v, lat, seen);
    want = exp_q.pop_front();
    checks++; if (!seen || v !== want) begin errors++; $display("FAIL busy_sdf got=%h want=%h", v, want); end
    @(negedge clk_in);
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL busy_ready_back got=%b want=1", ready_out); end
    pulses = 0;
    repeat (60) begin
      @(negedge clk_in);
      if (valid_out) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL busy_extra_pulse got=%0d want=0", pulses); end
  endtask

  task automatic test_reset_mid_root;
    logic [31:0] v, want;
    int lat, pulses;
    bit ok, seen;
    send_point(pt(2 << 16, 2 << 16, 1 << 16), ok);
    repeat (15) @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    checks++; if (ready_out !== 1'b1 || valid_out !== 1'b0 || sdf_out !== 32'h0) begin
      errors++; $display("FAIL midroot_reset ready=%b valid=%b sdf=%h want 1/0/00000000", ready_out, valid_out, sdf_out);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    pulses = 0;
    repeat (50) begin
      @(negedge clk_in);
      if (valid_out) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midroot_no_pulse got=%0d want=0", pulses); end
    send_point(pt(-(4 << 16), 0, -(5 << 16)), ok);
    exp_q.push_back(32'h00050000);
    collect(v, lat, seen);
    want = exp_q.pop_front();
    checks++; if (!seen || lat !== 35 || v !== want) begin
      errors++; $display("FAIL midroot_after got=%h lat=%0d want=%h lat=35", v, lat, want);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v, want;
    int lat;
    bit ok, seen;
    @(negedge clk_in);
    send_point(pt(0, 3 << 16, 0), ok);
    exp_q.push_back(32'h00020000);
    collect(v, lat, seen);
    want = exp_q.pop_front();
    checks++; if (!seen || v !== want) begin errors++; $display("FAIL b2b_first got=%h want=%h", v, want); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL b2b_ready_on_valid got=%b want=1", ready_out); end
    send_point(pt(0, 0, -(2 << 16)), ok);
    exp_q.push_back(32'h00010000);
    collect(v, lat, seen);
    want = exp_q.pop_front();
    checks++; if (!seen || lat !== 35 || v !== want) begin
      errors++; $display("FAIL b2b_second got=%h lat=%0d want=%h lat=35", v, lat, want);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_in = 1'b0;
    valid_in = 1'b0;
    point_in = 96'd0;
    test_reset;
    test_vectors;
    test_random;
    test_ignore_busy;
    test_reset_mid_root;
    test_back_to_back;
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
